// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART frame arbiter: frame width, FSM encoding, index width helper.
package uart_arb_pkg;

    localparam int unsigned FRAME_W = 48;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Index width that never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests to start after ptr, take the lowest
// set bit, rotate the index back into requester space.
module rr_priority_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic [ID_W-1:0]  o_win_id,
    output logic             o_any_req
);

    logic [N_REQ-1:0] w_rot;
    int unsigned      w_start;
    int unsigned      w_idx;
    int unsigned      w_pos;
    int unsigned      w_sum;

    always_comb begin
        w_rot   = '0;
        w_idx   = 0;
        w_pos   = 0;
        w_start = int'(i_ptr) + 1;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_idx = w_start + j;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            w_rot[j] = i_req[w_idx];
        end
        for (int unsigned k = N_REQ; k > 0; k--) begin
            if (w_rot[k-1]) w_pos = k - 1;
        end
        w_sum = w_start + w_pos;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        o_win_id  = ID_W'(w_sum);
        o_any_req = |i_req;
        o_winner  = o_any_req ? (N_REQ'(1) << o_win_id) : '0;
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin sharing of one UART frame transmitter: captures the winning frame, pulses
// tx_new_data, tracks tx_busy to end of frame and flags a sticky ack timeout.
module uart_frame_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned FRAME_W     = uart_arb_pkg::FRAME_W,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*FRAME_W-1:0]     req_data,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             done,
    output logic [id_width(N_REQ)-1:0]   active_id,
    input  logic                         pause,
    output logic [FRAME_W-1:0]           tx_data,
    output logic                         tx_new_data,
    output logic                         tx_block,
    input  logic                         tx_busy,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam int unsigned ID_W  = id_width(N_REQ);
    localparam int unsigned TMR_W = id_width(ACK_TIMEOUT);

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [TMR_W-1:0]   r_timer;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [ID_W-1:0]    r_active_id;
    logic [FRAME_W-1:0] r_tx_data;
    logic               r_tx_new_data;
    logic               r_tx_block;
    logic               r_err;

    logic [N_REQ-1:0]   w_winner;
    logic [ID_W-1:0]    w_win_id;
    logic               w_any_req;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_winner  (w_winner),
        .o_win_id  (w_win_id),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= ID_W'(N_REQ - 1);
            r_timer       <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_active_id   <= '0;
            r_tx_data     <= '0;
            r_tx_new_data <= 1'b0;
            r_tx_block    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_grant    <= '0;
            r_done     <= '0;
            r_tx_block <= pause;
            // Clear first so a timeout set in the case below overrides it.
            if (err_clear) r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!pause && !tx_busy && w_any_req) begin
                        r_state       <= ST_ISSUE;
                        r_grant       <= w_winner;
                        r_tx_data     <= req_data[w_win_id*FRAME_W +: FRAME_W];
                        r_active_id   <= w_win_id;
                        r_tx_new_data <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_tx_new_data <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_ptr   <= r_active_id;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_done  <= N_REQ'(1) << r_active_id;
                        r_ptr   <= r_active_id;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_new_data <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign active_id   = r_active_id;
    assign tx_data     = r_tx_data;
    assign tx_new_data = r_tx_new_data;
    assign tx_block    = r_tx_block;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter with a simple UART TX busy model.
module tb_uart_frame_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned FW  = 48;
    localparam int unsigned ACK = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [1:0]      active_id;
    logic            pause;
    logic [FW-1:0]   tx_data;
    logic            tx_new_data;
    logic            tx_block;
    logic            tx_busy = 1'b0;
    logic            err_timeout;
    logic            err_clear;

    int checks   = 0;
    int failures = 0;

    logic     tx_ack_en = 1'b1;
    int       busy_len  = 5;
    int       tx_cnt    = 0;
    logic [FW-1:0] fdata [N];

    uart_frame_arbiter #(
        .N_REQ       (N),
        .FRAME_W     (FW),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .active_id   (active_id),
        .pause       (pause),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_block    (tx_block),
        .tx_busy     (tx_busy),
        .err_timeout (err_timeout),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    // UART TX model: busy rises the cycle after the start pulse, stays up busy_len cycles.
    always @(posedge clk) begin
        if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_busy <= 1'b0;
        end else if (tx_new_data && tx_ack_en) begin
            tx_busy <= 1'b1;
            tx_cnt  <= busy_len;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400 && tx_busy; i++) tick();
        tick();
    endtask

    // Advance until a grant appears; n = cycles taken, or -1 on expiry.
    task automatic wait_grant(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (grant != '0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (grant !== '0 || done !== '0 || tx_new_data !== 1'b0 || tx_data !== '0 ||
            tx_block !== 1'b0 || err_timeout !== 1'b0 || active_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%b done=%b txnd=%b data=%h blk=%b err=%b id=%0d exp all zero",
                     grant, done, tx_new_data, tx_data, tx_block, err_timeout, active_id);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        bit seen_busy = 0;
        bit fell = 0;
        busy_len = 300;
        req_data[2*FW +: FW] = 48'hA1B2C3D4E5F6;
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || tx_new_data !== 1'b1 || active_id !== 2'd2) begin
            failures++;
            $display("FAIL single_grant got grant=%b txnd=%b id=%0d exp 0100 1 2", grant, tx_new_data, active_id);
        end
        checks++;
        if (tx_data !== 48'hA1B2C3D4E5F6) begin
            failures++;
            $display("FAIL single_data got %h exp a1b2c3d4e5f6", tx_data);
        end
        req = '0;
        req_data[2*FW +: FW] = 48'h0;
        tick();
        checks++;
        if (grant !== '0 || tx_new_data !== 1'b0 || tx_data !== 48'hA1B2C3D4E5F6) begin
            failures++;
            $display("FAIL single_pulse_len got grant=%b txnd=%b data=%h exp 0000 0 a1b2c3d4e5f6",
                     grant, tx_new_data, tx_data);
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx_busy) seen_busy = 1;
            else if (seen_busy) begin
                fell = 1;
                break;
            end
        end
        checks++;
        if (!fell || done !== '0) begin
            failures++;
            $display("FAIL single_busy_fall got fell=%b done=%b exp 1 0000", fell, done);
        end
        tick();
        checks++;
        if (done !== 4'b0100 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_done got done=%b err=%b exp 0100 0", done, err_timeout);
        end
        tick();
        checks++;
        if (done !== '0) begin
            failures++;
            $display("FAIL single_done_len got %b exp 0000", done);
        end
    endtask

    task automatic test_round_robin;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int pulses, dones, n;
        busy_len = 3;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*FW +: FW] = fdata[i];
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            pulses = 0;
            dones  = 0;
            n      = -1;
            for (int c = 1; c <= 60; c++) begin
                tick();
                if (tx_new_data) pulses++;
                if (done != '0) dones++;
                if (grant != '0) begin
                    n = c;
                    break;
                end
            end
            checks++;
            if (n < 0 || grant !== (4'b0001 << exp_order[f]) || tx_data !== fdata[exp_order[f]]) begin
                failures++;
                $display("FAIL rr_order frame=%0d got grant=%b data=%h exp id=%0d data=%h",
                         f, grant, tx_data, exp_order[f], fdata[exp_order[f]]);
            end
            checks++;
            if (pulses != 1 || dones != (f == 0 ? 0 : 1)) begin
                failures++;
                $display("FAIL rr_pulses frame=%0d got pulses=%0d dones=%0d exp 1 %0d",
                         f, pulses, dones, (f == 0 ? 0 : 1));
            end
        end
        req = '0;
    endtask

    task automatic test_rr_rearm;
        int n;
        bit got;
        busy_len = 3;
        do_reset();
        req = 4'b1001;
        wait_grant(10, n);
        checks++;
        if (n != 1 || grant !== 4'b0001) begin
            failures++;
            $display("FAIL rearm_first got grant=%b n=%0d exp 0001 1", grant, n);
        end
        req = 4'b1000;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done != '0) begin
                got = 1;
                break;
            end
        end
        req = 4'b1001;
        checks++;
        if (!got || done !== 4'b0001) begin
            failures++;
            $display("FAIL rearm_done got done=%b seen=%b exp 0001 1", done, got);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || active_id !== 2'd3) begin
            failures++;
            $display("FAIL rearm_next got grant=%b id=%0d exp 1000 3", grant, active_id);
        end
        req = '0;
    endtask

    task automatic test_timeout;
        int n, ndone;
        busy_len = 3;
        do_reset();
        tx_ack_en = 1'b0;
        req = 4'b1111 & 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL to_grant got %b exp 0010", grant);
        end
        req = '0;
        n = -1;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done != '0) ndone++;
            if (err_timeout) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != ACK + 1 || ndone != 0) begin
            failures++;
            $display("FAIL to_latency got cycles=%0d dones=%0d exp %0d 0", n, ndone, ACK + 1);
        end
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_next_grant got grant=%b err=%b exp 0100 1", grant, err_timeout);
        end
        req = '0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_clear got %b exp 0", err_timeout);
        end
        for (int i = 2; i <= ACK; i++) tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_early got %b exp 0", err_timeout);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_set_wins got %b exp 1", err_timeout);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky got %b exp 1", err_timeout);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_clear2 got %b exp 0", err_timeout);
        end
        tx_ack_en = 1'b1;
    endtask

    task automatic test_pause;
        int n, stray;
        bit got;
        busy_len = 5;
        do_reset();
        req = 4'b0001;
        wait_grant(10, n);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL pause_grant got %b exp 0001", grant);
        end
        pause = 1'b1;
        req   = 4'b0010;
        got   = 0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done != '0) begin
                got = 1;
                break;
            end
            if (grant != '0) stray++;
        end
        checks++;
        if (!got || done !== 4'b0001 || stray != 0) begin
            failures++;
            $display("FAIL pause_done got done=%b seen=%b stray=%0d exp 0001 1 0", done, got, stray);
        end
        checks++;
        if (tx_block !== 1'b1) begin
            failures++;
            $display("FAIL pause_block got %b exp 1", tx_block);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (grant != '0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL pause_hold got stray_grants=%0d exp 0", stray);
        end
        pause = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010 || tx_block !== 1'b0) begin
            failures++;
            $display("FAIL pause_release got grant=%b blk=%b exp 0010 0", grant, tx_block);
        end
        req = '0;
    endtask

    task automatic test_reset_mid;
        int n, stray;
        bit fell;
        busy_len = 20;
        do_reset();
        req_data[2*FW +: FW] = 48'h123456789ABC;
        req = 4'b0100;
        wait_grant(10, n);
        req = '0;
        for (int i = 0; i < 10 && !tx_busy; i++) tick();
        tick();
        tick();
        req = 4'b0001;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_data !== '0 || tx_new_data !== 1'b0 || grant !== '0 || done !== '0 ||
            active_id !== 2'd0 || tx_block !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_outputs got data=%h txnd=%b grant=%b done=%b id=%0d blk=%b busy=%b exp zeros busy=1",
                     tx_data, tx_new_data, grant, done, active_id, tx_block, tx_busy);
        end
        tick();
        rst = 1'b0;
        stray = 0;
        fell  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant != '0) stray++;
            if (!tx_busy) begin
                fell = 1;
                break;
            end
        end
        checks++;
        if (!fell || stray != 0) begin
            failures++;
            $display("FAIL rstmid_hold got fell=%b stray_grants=%0d exp 1 0", fell, stray);
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || active_id !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_grant got grant=%b id=%0d exp 0001 0", grant, active_id);
        end
        req = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        pause     = 1'b0;
        err_clear = 1'b0;
        fdata[0]  = 48'h0000_1111_2222;
        fdata[1]  = 48'h3333_4444_5555;
        fdata[2]  = 48'h6666_7777_8888;
        fdata[3]  = 48'h9999_AAAA_BBBB;
        test_reset();
        test_single();
        test_round_robin();
        test_rr_rearm();
        test_timeout();
        test_pause();
        test_reset_mid();
        for (int i = 0; i < 40; i++) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
